fifo_ctrl_param: RTL and testbench
==================================

Name: fifo_ctrl_param

Overview:
- Parametrised successor of the button-driven FIFO path: input synchroniser, edge-detect strobe generation, and a synchronous circular-buffer FIFO in one block.
- Adds status flags, an occupancy count, sticky overflow/underflow errors, a read-valid strobe and a selectable level/edge mode.
- Sits between board-level push-button/switch inputs and LED or debug outputs on the Arty7 top level.

Parameters:
- DATA_W, 8: data width in bits.
- DEPTH, 16: number of entries; power of 2, minimum 2. ADDR_W = log2(DEPTH) is a derived localparam.
- SYNC_STAGES, 2: number of synchroniser flops on enables and data; minimum 2.
- EDGE_MODE, 1: 1 = one operation per rising edge of an enable; 0 = one operation per clock while the synchronised enable is high.
- AFULL_TH, DEPTH-1: almost_full is asserted when count >= AFULL_TH.
- AEMPTY_TH, 1: almost_empty is asserted when count <= AEMPTY_TH.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable_read  in  1  asynchronous read request.
- enable_write  in  1  asynchronous write request.
- value_to_write  in  DATA_W  write data; quasi-static around write requests.
- clear_err  in  1  synchronous clear for the sticky error flags.
- value_to_read  out  DATA_W  last popped word, registered.
- read_valid  out  1  one-cycle pulse when value_to_read has been updated.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst=0, asynchronous):
  - Pointers = 0, count = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - value_to_read = 0, read_valid = 0, overflow = 0, underflow = 0.
  - Synchroniser flops = 0; edge-history flops = 1, so an enable held through reset release produces no strobe.
  - Memory contents are not reset.
- Synchroniser: enable_read, enable_write and value_to_write each pass through SYNC_STAGES flops, so data stays aligned with the write enable.
- Strobes:
  - EDGE_MODE=1: strobe = synced & ~history; history <= synced every cycle.
  - EDGE_MODE=0: strobe = synced.
- Latency:
  - An enable first sampled high at edge N commits its operation at edge N+SYNC_STAGES.
  - count, flags and value_to_read update at that same edge.
  - read_valid is high for the one cycle following that edge.
- Write strobe when not full: mem[wptr] <= data; wptr increments modulo DEPTH; count increments.
- Read strobe when not empty: value_to_read <= mem[rptr]; rptr increments modulo DEPTH; count decrements; read_valid pulses.
- Simultaneous read and write strobes:
  - 0 < count < DEPTH: both occur, count unchanged.
  - Full: both occur (the read frees a slot), count stays at DEPTH, no overflow.
  - Empty: write occurs, read is rejected (no fall-through), underflow is set, count becomes 1.
- Write when full with no read: data dropped, pointers and count unchanged, overflow <= 1.
- Read when empty with no write: value_to_read holds its value, read_valid stays 0, underflow <= 1.
- clear_err=1 clears both sticky errors at the next edge. A new error in the same cycle takes priority and the flag stays set.
- Flags are registered and derived from next-count, so they are always consistent with count. Pointer wrap needs no special case because DEPTH is a power of 2.
- Reset mid-operation aborts any in-flight strobe; the FIFO restarts empty.

Test Plan (DATA_W=8, DEPTH=4, SYNC_STAGES=2, EDGE_MODE=1, AFULL_TH=3, AEMPTY_TH=1):
- Reset, then idle 5 cycles -> count=0, empty=1, almost_empty=1, value_to_read=0x00, no strobes.
- Pulse enable_write with data 0x11, 0x22, 0x33, 0x44 (each held 3 cycles, 3 low) -> count steps 1..4; almost_full rises at 3; full=1 at 4; each write lands exactly 2 edges after its first-sampled edge.
- Fifth write with 0x55 while full -> count=4, overflow=1. Then four reads -> 0x11, 0x22, 0x33, 0x44 with one read_valid each, empty=1 at the end (0x55 never appears).
- Hold enable_write high for 10 cycles -> exactly one write (edge mode). Repeat with EDGE_MODE=0 and DEPTH=4 -> 4 writes, then overflow=1.
- Empty FIFO, assert enable_read and enable_write with 0x5A on the same edge -> count=1, underflow=1, read_valid=0. Next read returns 0x5A. clear_err -> underflow=0.
- Fill to 2 entries, assert rst=0 for 1 cycle mid-operation with enable_write held high -> count=0, empty=1, no write after release until enable_write toggles.

Source files
------------

// File: rtl/fifo_ctrl_param_if.sv
// fifo_ctrl_param_if: request/status bundle between board inputs and the FIFO.
// master drives enables, write data and clear_err; slave returns data, flags, count, errors.
interface fifo_ctrl_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              enable_read;
  logic              enable_write;
  logic [DATA_W-1:0] value_to_write;
  logic              clear_err;
  logic [DATA_W-1:0] value_to_read;
  logic              read_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output enable_read,
    output enable_write,
    output value_to_write,
    output clear_err,
    input  value_to_read,
    input  read_valid,
    input  full,
    input  empty,
    input  almost_full,
    input  almost_empty,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  enable_read,
    input  enable_write,
    input  value_to_write,
    input  clear_err,
    output value_to_read,
    output read_valid,
    output full,
    output empty,
    output almost_full,
    output almost_empty,
    output count,
    output overflow,
    output underflow
  );
endinterface

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: synchroniser + strobe gen + circular FIFO with flags and sticky errors.
// Ports: clk, rst (async active-low), bus (slave: enables/data in, data/flags/count/errors out).
module fifo_ctrl_param #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int AFULL_TH    = DEPTH - 1,
  parameter int AEMPTY_TH   = 1
) (
  input logic              clk,
  input logic              rst,
  fifo_ctrl_param_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] AF_TH =
    (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_TH =
    (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0] FULL_CNT =
    (ADDR_W+1)'(DEPTH);
  localparam logic EDGE_SEL = (EDGE_MODE != 0);

  logic [SYNC_STAGES-1:0] rd_sync;
  logic [SYNC_STAGES-1:0] wr_sync;
  logic [SYNC_STAGES-1:0] primed;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] dat_sync;

  logic              rd_lvl;
  logic              wr_lvl;
  logic [DATA_W-1:0] wdata;
  logic              rd_hist;
  logic              wr_hist;
  logic              rd_stb;
  logic              wr_stb;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              afull_q;
  logic              aempty_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              ovf_q;
  logic              unf_q;

  logic do_rd;
  logic do_wr;
  logic ovf_set;
  logic unf_set;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_sync  <= '0;
      wr_sync  <= '0;
      primed   <= '0;
      dat_sync <= '0;
    end else begin
      rd_sync  <= {rd_sync[SYNC_STAGES-2:0],
                   bus.enable_read};
      wr_sync  <= {wr_sync[SYNC_STAGES-2:0],
                   bus.enable_write};
      primed   <= {primed[SYNC_STAGES-2:0], 1'b1};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0],
                   bus.value_to_write};
    end
  end

  assign rd_lvl = rd_sync[SYNC_STAGES-1];
  assign wr_lvl = wr_sync[SYNC_STAGES-1];
  assign wdata  = dat_sync[SYNC_STAGES-1];

  // History holds its reset value of 1 until the sync chain is
  // flushed of reset zeros, so an enable that is already high
  // when reset releases never looks like a rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_hist <= 1'b1;
      wr_hist <= 1'b1;
    end else if (primed[SYNC_STAGES-1]) begin
      rd_hist <= rd_lvl;
      wr_hist <= wr_lvl;
    end
  end

  assign rd_stb = rd_lvl & (~EDGE_SEL | ~rd_hist);
  assign wr_stb = wr_lvl & (~EDGE_SEL | ~wr_hist);

  // A read on a full FIFO frees the slot the write reuses;
  // a read on an empty FIFO never falls through to the write.
  always_comb begin
    do_rd     = rd_stb & ~empty_q;
    do_wr     = wr_stb & (~full_q | do_rd);
    ovf_set   = wr_stb & ~do_wr;
    unf_set   = rd_stb & empty_q;
    count_nxt = count_q;
    unique case (1'b1)
      do_wr & ~do_rd: count_nxt = count_q + 1'b1;
      do_rd & ~do_wr: count_nxt = count_q - 1'b1;
      default:        count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        rptr    <= rptr + 1'b1;
        rdata_q <= mem[rptr];
      end
      rvalid_q <= do_rd;
      count_q  <= count_nxt;
      full_q   <= (count_nxt == FULL_CNT);
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= AF_TH);
      aempty_q <= (count_nxt <= AE_TH);
    end
  end

  // A fresh error wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (bus.clear_err) begin
        ovf_q <= 1'b0;
      end
      if (unf_set) begin
        unf_q <= 1'b1;
      end else if (bus.clear_err) begin
        unf_q <= 1'b0;
      end
    end
  end

  assign bus.value_to_read = rdata_q;
  assign bus.read_valid    = rvalid_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  assign bus.almost_full   = afull_q;
  assign bus.almost_empty  = aempty_q;
  assign bus.count         = count_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: directed bench for fifo_ctrl_param, edge and level variants.
// Ports: none; drives clk/rst and two interface instances.
module tb_fifo_ctrl_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fifo_ctrl_param_if #(.DATA_W(8), .DEPTH(4)) be ();
  fifo_ctrl_param_if #(.DATA_W(8), .DEPTH(4)) bl ();

  fifo_ctrl_param #(
    .DATA_W(8), .DEPTH(4), .SYNC_STAGES(2),
    .EDGE_MODE(1), .AFULL_TH(3), .AEMPTY_TH(1)
  ) u_edge (
    .clk(clk), .rst(rst), .bus(be)
  );

  fifo_ctrl_param #(
    .DATA_W(8), .DEPTH(4), .SYNC_STAGES(2),
    .EDGE_MODE(0), .AFULL_TH(3), .AEMPTY_TH(1)
  ) u_lvl (
    .clk(clk), .rst(rst), .bus(bl)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_pulse(input logic [7:0] d);
    be.value_to_write = d;
    be.enable_write   = 1'b1;
    tick(3);
    be.enable_write   = 1'b0;
    tick(3);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_cmp++;
      if (be.read_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_idle_rv: got %b want 0",
                 be.read_valid);
      end
    end
    n_cmp++;
    if (be.count !== 3'd0) begin
      n_bad++;
      $display("FAIL rst_count: got %0d want 0", be.count);
    end
    n_cmp++;
    if ({be.full, be.almost_full, be.empty,
         be.almost_empty, be.overflow,
         be.underflow} !== 6'b001100) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 001100",
               {be.full, be.almost_full, be.empty,
                be.almost_empty, be.overflow, be.underflow});
    end
    n_cmp++;
    if (be.value_to_read !== 8'h00) begin
      n_bad++;
      $display("FAIL rst_vtr: got %h want 00",
               be.value_to_read);
    end
    n_cmp++;
    if (bl.count !== 3'd0 || bl.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_lvl: got cnt %0d empty %b want 0 1",
               bl.count, bl.empty);
    end
  endtask

  task automatic test_fill;
    logic [3:0] exp;
    for (int k = 1; k <= 4; k++) begin
      be.value_to_write = 8'(8'h11 * k);
      be.enable_write   = 1'b1;
      tick(2);
      n_cmp++;
      if (be.count !== 3'(k - 1)) begin
        n_bad++;
        $display("FAIL wr_early_%0d: got %0d want %0d",
                 k, be.count, k - 1);
      end
      tick(1);
      n_cmp++;
      if (be.count !== 3'(k)) begin
        n_bad++;
        $display("FAIL wr_commit_%0d: got %0d want %0d",
                 k, be.count, k);
      end
      exp = {k == 4, k >= 3, 1'b0, k <= 1};
      n_cmp++;
      if ({be.full, be.almost_full, be.empty,
           be.almost_empty} !== exp) begin
        n_bad++;
        $display("FAIL wr_flags_%0d: got %b want %b", k,
                 {be.full, be.almost_full, be.empty,
                  be.almost_empty}, exp);
      end
      be.enable_write = 1'b0;
      tick(3);
    end
  endtask

  task automatic test_overflow_drain;
    logic [7:0] d;
    wr_pulse(8'h55);
    n_cmp++;
    if ({be.count, be.full, be.overflow}
        !== {3'd4, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_set: got cnt %0d full %b ovf %b want 4 1 1",
               be.count, be.full, be.overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      d = 8'(8'h11 * k);
      be.enable_read = 1'b1;
      tick(3);
      n_cmp++;
      if (be.value_to_read !== d || be.read_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL rd_data_%0d: got %h/%b want %h/1",
                 k, be.value_to_read, be.read_valid, d);
      end
      n_cmp++;
      if (be.count !== 3'(4 - k)) begin
        n_bad++;
        $display("FAIL rd_count_%0d: got %0d want %0d",
                 k, be.count, 4 - k);
      end
      be.enable_read = 1'b0;
      tick(1);
      n_cmp++;
      if (be.read_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rv_pulse_%0d: got %b want 0",
                 k, be.read_valid);
      end
      tick(2);
    end
    n_cmp++;
    if ({be.empty, be.almost_empty, be.overflow}
        !== 3'b111) begin
      n_bad++;
      $display("FAIL drain_flags: got %b want 111",
               {be.empty, be.almost_empty, be.overflow});
    end
    be.clear_err = 1'b1;
    tick(1);
    be.clear_err = 1'b0;
    n_cmp++;
    if (be.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: got %b want 0", be.overflow);
    end
  endtask

  task automatic test_hold_level;
    be.value_to_write = 8'h66;
    bl.value_to_write = 8'h77;
    be.enable_write   = 1'b1;
    bl.enable_write   = 1'b1;
    tick(10);
    be.enable_write   = 1'b0;
    bl.enable_write   = 1'b0;
    tick(4);
    n_cmp++;
    if (be.count !== 3'd1 || be.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_edge: got cnt %0d ovf %b want 1 0",
               be.count, be.overflow);
    end
    n_cmp++;
    if ({bl.count, bl.full, bl.overflow}
        !== {3'd4, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL hold_lvl: got cnt %0d full %b ovf %b want 4 1 1",
               bl.count, bl.full, bl.overflow);
    end
    be.enable_read = 1'b1;
    bl.enable_read = 1'b1;
    tick(1);
    bl.enable_read = 1'b0;
    tick(2);
    be.enable_read = 1'b0;
    tick(3);
    n_cmp++;
    if (be.value_to_read !== 8'h66 || be.count !== 3'd0) begin
      n_bad++;
      $display("FAIL hold_edge_rd: got %h cnt %0d want 66 0",
               be.value_to_read, be.count);
    end
    n_cmp++;
    if (bl.value_to_read !== 8'h77 || bl.count !== 3'd3) begin
      n_bad++;
      $display("FAIL lvl_rd: got %h cnt %0d want 77 3",
               bl.value_to_read, bl.count);
    end
  endtask

  task automatic test_simul_empty;
    be.value_to_write = 8'h5A;
    be.enable_read    = 1'b1;
    be.enable_write   = 1'b1;
    tick(3);
    n_cmp++;
    if ({be.count, be.underflow, be.read_valid}
        !== {3'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL simul: got cnt %0d unf %b rv %b want 1 1 0",
               be.count, be.underflow, be.read_valid);
    end
    n_cmp++;
    if (be.value_to_read !== 8'h66) begin
      n_bad++;
      $display("FAIL simul_hold: got %h want 66",
               be.value_to_read);
    end
    be.enable_read  = 1'b0;
    be.enable_write = 1'b0;
    tick(3);
    be.enable_read = 1'b1;
    tick(3);
    n_cmp++;
    if (be.value_to_read !== 8'h5A || be.read_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL simul_rd: got %h/%b want 5a/1",
               be.value_to_read, be.read_valid);
    end
    be.enable_read = 1'b0;
    tick(3);
    n_cmp++;
    if (be.underflow !== 1'b1 || be.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL unf_sticky: got unf %b empty %b want 1 1",
               be.underflow, be.empty);
    end
    be.clear_err = 1'b1;
    tick(1);
    be.clear_err = 1'b0;
    n_cmp++;
    if (be.underflow !== 1'b0) begin
      n_bad++;
      $display("FAIL unf_clear: got %b want 0", be.underflow);
    end
  endtask

  task automatic test_reset_mid;
    wr_pulse(8'h01);
    wr_pulse(8'h02);
    n_cmp++;
    if (be.count !== 3'd2) begin
      n_bad++;
      $display("FAIL mid_pre: got %0d want 2", be.count);
    end
    be.value_to_write = 8'h03;
    be.enable_write   = 1'b1;
    tick(1);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({be.count, be.empty, be.almost_empty}
        !== {3'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_rst: got cnt %0d empty %b ae %b want 0 1 1",
               be.count, be.empty, be.almost_empty);
    end
    tick(1);
    rst = 1'b1;
    tick(8);
    n_cmp++;
    if (be.count !== 3'd0 || be.empty !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_held: got cnt %0d empty %b want 0 1",
               be.count, be.empty);
    end
    be.enable_write = 1'b0;
    tick(3);
    be.enable_write = 1'b1;
    tick(3);
    be.enable_write = 1'b0;
    tick(3);
    n_cmp++;
    if (be.count !== 3'd1) begin
      n_bad++;
      $display("FAIL mid_toggle: got %0d want 1", be.count);
    end
    be.enable_read = 1'b1;
    tick(3);
    be.enable_read = 1'b0;
    n_cmp++;
    if (be.value_to_read !== 8'h03) begin
      n_bad++;
      $display("FAIL mid_rd: got %h want 03",
               be.value_to_read);
    end
    tick(3);
  endtask

  initial begin
    be.enable_read    = 1'b0;
    be.enable_write   = 1'b0;
    be.value_to_write = 8'h00;
    be.clear_err      = 1'b0;
    bl.enable_read    = 1'b0;
    bl.enable_write   = 1'b0;
    bl.value_to_write = 8'h00;
    bl.clear_err      = 1'b0;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_hold_level();
    test_simul_empty();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
